// File: rtl/nibble_serial_adder.sv
// Nibble-serial W-bit adder: one 4-bit carry-lookahead slice reused over NIB clocks, LSB nibble first.
// Latency NIB+1 edges from accepted start to done; start is ignored while busy.
module nibble_serial_adder #(
    parameter int NIB = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4*NIB-1:0]  a,
    input  logic [4*NIB-1:0]  b,
    input  logic              ci,
    output logic              busy,
    output logic              done,
    output logic [4*NIB-1:0]  s,
    output logic              co,
    output logic              ovf,
    output logic              pg,
    output logic              gg
);
    localparam int W  = 4 * NIB;
    localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_sum;
    logic            r_carry;
    logic [CW-1:0]   r_cnt;
    logic            r_acc_p;
    logic            r_acc_g;
    logic [W-1:0]    r_s;
    logic            r_co;
    logic            r_ovf;
    logic            r_pg;
    logic            r_gg;

    logic [CW+1:0]   w_base;
    logic [3:0]      w_an;
    logic [3:0]      w_bn;
    logic [3:0]      w_p;
    logic [3:0]      w_g;
    logic [4:0]      w_c;
    logic            w_grp_p;
    logic            w_grp_g;
    logic [3:0]      w_sum4;
    logic [W-1:0]    w_sum_next;
    logic            w_accept;
    logic            w_last;

    assign w_base   = {r_cnt, 2'b00};
    assign w_an     = r_a[w_base +: 4];
    assign w_bn     = r_b[w_base +: 4];
    assign w_p      = w_an ^ w_bn;
    assign w_g      = w_an & w_bn;
    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_cnt == CW'(NIB - 1));

    // Flattened lookahead: every carry is a two-level function of g, p and the incoming carry.
    assign w_grp_p = &w_p;
    assign w_grp_g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                   | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign w_c[0]  = r_carry;
    assign w_c[1]  = w_g[0] | (w_p[0] & r_carry);
    assign w_c[2]  = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_carry);
    assign w_c[3]  = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                   | (w_p[2] & w_p[1] & w_p[0] & r_carry);
    assign w_c[4]  = w_grp_g | (w_grp_p & r_carry);
    assign w_sum4  = w_p ^ w_c[3:0];

    always_comb begin
        w_sum_next = r_sum;
        w_sum_next[w_base +: 4] = w_sum4;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_acc_p <= 1'b0;
            r_acc_g <= 1'b0;
            r_s     <= '0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
            r_pg    <= 1'b0;
            r_gg    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b;
                r_carry <= ci;
                r_sum   <= '0;
                r_cnt   <= '0;
                r_acc_p <= 1'b1;
                r_acc_g <= 1'b0;
            end else if (r_state == S_RUN) begin
                r_sum   <= w_sum_next;
                r_carry <= w_c[4];
                r_acc_p <= r_acc_p & w_grp_p;
                r_acc_g <= w_grp_g | (w_grp_p & r_acc_g);
                if (w_last) begin
                    // w_c[3] of the top nibble is the carry into bit W-1.
                    r_s   <= w_sum_next;
                    r_co  <= w_c[4];
                    r_ovf <= w_c[3] ^ w_c[4];
                    r_pg  <= r_acc_p & w_grp_p;
                    r_gg  <= w_grp_g | (w_grp_p & r_acc_g);
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign s    = r_s;
    assign co   = r_co;
    assign ovf  = r_ovf;
    assign pg   = r_pg;
    assign gg   = r_gg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (NIB=4): inputs driven and outputs sampled on the falling edge.
module tb_nibble_serial_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        ci = 1'b0;
    logic        busy, done, co, ovf, pg, gg;
    logic [15:0] s;

    int n_checks = 0;
    int n_pass   = 0;

    nibble_serial_adder #(.NIB(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .ci(ci),
        .busy(busy), .done(done), .s(s), .co(co), .ovf(ovf), .pg(pg), .gg(gg)
    );

    always #5 clk = ~clk;

    // Pulses start for one cycle and watches 12 falling edges for busy/done and the result.
    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic ici,
                          output int lat, output int ndone, output int both,
                          output logic [15:0] rs, output logic [3:0] rflags);
        int rise;
        @(negedge clk);
        a = ia; b = ib; ci = ici; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1; ndone = 0; both = 0; rise = -1;
        rs = 'x; rflags = 'x;
        for (int i = 0; i < 12; i++) begin
            if (busy && rise < 0) rise = i;
            if (busy && done) both++;
            if (done) begin
                ndone++;
                if (lat < 0) lat = i - rise;
                rs = s;
                rflags = {co, ovf, pg, gg};
            end
            if (i < 11) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) $display("FAIL reset_ctrl: busy,done=%b expected 00", {busy, done});
        else n_pass++;
        n_checks++;
        if (s !== 16'h0000) $display("FAIL reset_s: got %h expected 0000", s);
        else n_pass++;
        n_checks++;
        if ({co, ovf, pg, gg} !== 4'b0000) $display("FAIL reset_flags: got %b expected 0000", {co, ovf, pg, gg});
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_small();
        int lat, nd, both;
        logic [15:0] rs;
        logic [3:0]  fl;
        run_op(16'h0005, 16'h0003, 1'b1, lat, nd, both, rs, fl);
        n_checks++;
        if (rs !== 16'h0009) $display("FAIL small_s: got %h expected 0009", rs);
        else n_pass++;
        n_checks++;
        if (fl !== 4'b0000) $display("FAIL small_flags: co,ovf,pg,gg=%b expected 0000", fl);
        else n_pass++;
        n_checks++;
        if (lat !== 4) $display("FAIL small_latency: done %0d cycles after busy, expected 4", lat);
        else n_pass++;
        n_checks++;
        if (nd !== 1 || both !== 0) $display("FAIL small_pulse: done pulses=%0d overlap=%0d expected 1,0", nd, both);
        else n_pass++;
        n_checks++;
        if (s !== 16'h0009) $display("FAIL small_hold: s=%h expected 0009 while idle", s);
        else n_pass++;
    endtask

    task automatic test_carry_wrap();
        int lat, nd, both;
        logic [15:0] rs;
        logic [3:0]  fl;
        run_op(16'hFFFF, 16'h0001, 1'b0, lat, nd, both, rs, fl);
        n_checks++;
        if (rs !== 16'h0000) $display("FAIL wrap_s: got %h expected 0000", rs);
        else n_pass++;
        n_checks++;
        if (fl !== 4'b1001) $display("FAIL wrap_flags: co,ovf,pg,gg=%b expected 1001", fl);
        else n_pass++;
    endtask

    task automatic test_propagate();
        int lat, nd, both;
        logic [15:0] rs;
        logic [3:0]  fl;
        run_op(16'hAAAA, 16'h5555, 1'b1, lat, nd, both, rs, fl);
        n_checks++;
        if (rs !== 16'h0000) $display("FAIL prop_s: got %h expected 0000", rs);
        else n_pass++;
        n_checks++;
        if (fl !== 4'b1010) $display("FAIL prop_flags: co,ovf,pg,gg=%b expected 1010", fl);
        else n_pass++;
    endtask

    task automatic test_overflow();
        int lat, nd, both;
        logic [15:0] rs;
        logic [3:0]  fl;
        run_op(16'h7FFF, 16'h0001, 1'b0, lat, nd, both, rs, fl);
        n_checks++;
        if (rs !== 16'h8000) $display("FAIL ovf_s: got %h expected 8000", rs);
        else n_pass++;
        n_checks++;
        if (fl !== 4'b0100) $display("FAIL ovf_flags: co,ovf,pg,gg=%b expected 0100", fl);
        else n_pass++;
    endtask

    task automatic test_start_midrun();
        int nd, done_at;
        logic [15:0] rs;
        logic        rco;
        @(negedge clk);
        a = 16'h0005; b = 16'h0003; ci = 1'b1; start = 1'b1;
        nd = 0; done_at = -1; rs = 'x; rco = 1'bx;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (i == 1) begin a = 16'h1234; b = 16'h1111; ci = 1'b0; start = 1'b1; end
            if (i == 2) start = 1'b0;
            if (done) begin
                nd++;
                if (done_at < 0) done_at = i;
                rs = s; rco = co;
            end
        end
        n_checks++;
        if (rs !== 16'h0009 || rco !== 1'b0) $display("FAIL midrun_result: s=%h co=%b expected 0009,0", rs, rco);
        else n_pass++;
        n_checks++;
        if (nd !== 1 || done_at !== 4) $display("FAIL midrun_done: pulses=%0d at=%0d expected 1 at 4", nd, done_at);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int hold_bad, first_at, second_at;
        logic [15:0] s1, s2;
        logic        co1, co2, busy_after;
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; ci = 1'b0; start = 1'b1;
        hold_bad = 0; first_at = -1; second_at = -1;
        s1 = 'x; s2 = 'x; co1 = 1'bx; co2 = 1'bx; busy_after = 1'bx;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i == 0) begin a = 16'h1234; b = 16'h4321; ci = 1'b0; end
            if (i == 5) begin start = 1'b0; busy_after = busy; end
            if (i >= 5 && i <= 8 && (s !== 16'h0000 || co !== 1'b1)) hold_bad++;
            if (done && first_at < 0) begin first_at = i; s1 = s; co1 = co; end
            else if (done && second_at < 0) begin second_at = i; s2 = s; co2 = co; end
        end
        n_checks++;
        if (s1 !== 16'h0000 || co1 !== 1'b1 || first_at !== 4)
            $display("FAIL b2b_first: s=%h co=%b at=%0d expected 0000,1 at 4", s1, co1, first_at);
        else n_pass++;
        n_checks++;
        if (busy_after !== 1'b1) $display("FAIL b2b_busy: busy=%b after done expected 1", busy_after);
        else n_pass++;
        n_checks++;
        if (hold_bad !== 0) $display("FAIL b2b_hold: first result changed in %0d cycles expected 0", hold_bad);
        else n_pass++;
        n_checks++;
        if (s2 !== 16'h5555 || co2 !== 1'b0 || second_at !== 9)
            $display("FAIL b2b_second: s=%h co=%b at=%0d expected 5555,0 at 9", s2, co2, second_at);
        else n_pass++;
    endtask

    task automatic test_reset_midrun();
        int nd;
        @(negedge clk);
        a = 16'h7FFF; b = 16'h0001; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({busy, done} !== 2'b00) $display("FAIL abort_ctrl: busy,done=%b expected 00", {busy, done});
        else n_pass++;
        n_checks++;
        if (s !== 16'h0000 || {co, ovf, pg, gg} !== 4'b0000)
            $display("FAIL abort_outputs: s=%h flags=%b expected 0000,0000", s, {co, ovf, pg, gg});
        else n_pass++;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        n_checks++;
        if (nd !== 0) $display("FAIL abort_no_done: %0d busy/done cycles after abort expected 0", nd);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_small();
        test_carry_wrap();
        test_propagate();
        test_overflow();
        test_start_midrun();
        test_back_to_back();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
